mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arb_pkg.sv | 15 +
 rtl/mux2_bus.sv | 20 ++
 rtl/mux2_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and defaults for the two-way bus arbiter.
// Holds the FSM state enum and the default WIDTH / HOLD_MAX values.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_X = 2'd1,
    GNT_Y = 2'd2
  } arb_state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_HOLD_MAX = 8;
  localparam int HOLD_W       = 8;

endpackage

// File: rtl/mux2_bus.sv
// Per-bit AND-OR bus select, forced to zero when not enabled.
// Ports: en, sel (0 = a, 1 = b), a, b, y.
module mux2_bus #(
  parameter int WIDTH = 4
) (
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] sel_v;
  logic [WIDTH-1:0] en_v;

  assign sel_v = {WIDTH{sel}};
  assign en_v  = {WIDTH{en}};
  assign y     = en_v & ((~sel_v & a) | (sel_v & b));

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin bus arbiter with a shared data mux.
// Ports: clk, resetn (sync, active-low), req_x/req_y, data_x/data_y,
//   gnt_x/gnt_y, sel, m, m_valid.
// Optional preemption after HOLD_MAX cycles: MUX2_ARB_TIMEOUT_EN.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] data_x,
  input  logic [WIDTH-1:0] data_y,
  output logic             gnt_x,
  output logic             gnt_y,
  output logic             sel,
  output logic [WIDTH-1:0] m,
  output logic             m_valid
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last_y;
  logic       enter;
  logic       preempt_x;
  logic       preempt_y;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              at_top;

  assign at_top    = (hold_cnt == HOLD_TOP);
  assign preempt_x = at_top & req_y;
  assign preempt_y = at_top & req_x;

  // Cleared on every new grant and while idle; saturates at the top.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else if (enter || state_nxt == IDLE) begin
      hold_cnt <= '0;
    end else if (!at_top) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic [HOLD_W-1:0] unused_hold;

  assign unused_hold = HOLD_W'(HOLD_MAX - 1);
  assign preempt_x   = 1'b0;
  assign preempt_y   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          req_x & req_y:  state_nxt = last_y ? GNT_X : GNT_Y;
          req_x & ~req_y: state_nxt = GNT_X;
          ~req_x & req_y: state_nxt = GNT_Y;
          default:        state_nxt = IDLE;
        endcase
      end
      GNT_X: begin
        if (!req_x) begin
          state_nxt = req_y ? GNT_Y : IDLE;
        end else if (preempt_x) begin
          state_nxt = GNT_Y;
        end
      end
      GNT_Y: begin
        if (!req_y) begin
          state_nxt = req_x ? GNT_X : IDLE;
        end else if (preempt_y) begin
          state_nxt = GNT_X;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter = (state_nxt != state) && (state_nxt != IDLE);

  // sel only moves with a grant so it keeps its value through IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      sel     <= 1'b0;
      m_valid <= 1'b0;
      last_y  <= 1'b1;
    end else begin
      state   <= state_nxt;
      m_valid <= (state_nxt != IDLE);
      if (state_nxt != IDLE) begin
        sel <= (state_nxt == GNT_Y);
      end
      if (enter) begin
        last_y <= (state_nxt == GNT_Y);
      end
    end
  end

  assign gnt_x = (state == GNT_X);
  assign gnt_y = (state == GNT_Y);

  mux2_bus #(
    .WIDTH(WIDTH)
  ) u_bus (
    .en (m_valid),
    .sel(sel),
    .a  (data_x),
    .b  (data_y),
    .y  (m)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed table, timeout run,
// mid-grant reset and randomized traffic against an ownership model.
module tb_mux2_arbiter;

  localparam int WIDTH    = 4;
  localparam int HOLD_MAX = 8;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             req_x;
  logic             req_y;
  logic [WIDTH-1:0] data_x;
  logic [WIDTH-1:0] data_y;
  logic             gnt_x;
  logic             gnt_y;
  logic             sel;
  logic [WIDTH-1:0] m;
  logic             m_valid;

  int checks = 0;
  int errors = 0;

  // Model: owner 0 = nobody, 1 = X, 2 = Y.
  int owner = 0;
  int last  = 2;
  int held  = 0;
  bit msel  = 1'b0;

  always #5 clk = ~clk;

  mux2_arbiter #(
    .WIDTH(WIDTH),
    .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .req_x  (req_x),
    .req_y  (req_y),
    .data_x (data_x),
    .data_y (data_y),
    .gnt_x  (gnt_x),
    .gnt_y  (gnt_y),
    .sel    (sel),
    .m      (m),
    .m_valid(m_valid)
  );

  typedef struct {
    bit         rn;
    bit         rx;
    bit         ry;
    logic [3:0] dx;
    logic [3:0] dy;
    bit         gx;
    bit         gy;
    bit         s;
    logic [3:0] em;
  } vec_t;

  function automatic void model_step(bit rn, bit rx, bit ry);
    int nxt;
    if (!rn) begin
      owner = 0;
      last  = 2;
      held  = 0;
      msel  = 1'b0;
      return;
    end
    nxt = owner;
    if (owner == 0) begin
      if (rx && ry) nxt = (last == 1) ? 2 : 1;
      else if (rx) nxt = 1;
      else if (ry) nxt = 2;
    end else begin
      bit mine  = (owner == 1) ? rx : ry;
      bit other = (owner == 1) ? ry : rx;
      if (!mine) nxt = other ? 3 - owner : 0;
      else if (TMO && held >= HOLD_MAX && other) nxt = 3 - owner;
    end
    if (nxt != 0 && nxt != owner) begin
      held = 1;
      last = nxt;
      msel = (nxt == 2);
    end else if (nxt != 0) begin
      held++;
    end else begin
      held = 0;
    end
    owner = nxt;
  endfunction

  task automatic drive(bit rn, bit rx, bit ry,
                       logic [3:0] dx, logic [3:0] dy);
    resetn = rn;
    req_x  = rx;
    req_y  = ry;
    data_x = dx;
    data_y = dy;
    @(posedge clk);
    model_step(rn, rx, ry);
    #1;
  endtask

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] pack_out();
    return {gnt_x, gnt_y, sel, m_valid, m};
  endfunction

  function automatic logic [7:0] pack_model();
    logic [3:0] mm;
    mm = (owner == 0) ? 4'h0 : (msel ? data_y : data_x);
    return {owner == 1, owner == 2, msel, owner != 0, mm};
  endfunction

  vec_t vt[13];

  initial begin
    vt[0]  = '{0, 1, 1, 4'h5, 4'hA, 0, 0, 0, 4'h0};
    vt[1]  = '{0, 1, 1, 4'h5, 4'hA, 0, 0, 0, 4'h0};
    vt[2]  = '{1, 1, 1, 4'h5, 4'hA, 1, 0, 0, 4'h5};
    vt[3]  = '{1, 0, 1, 4'h5, 4'hA, 0, 1, 1, 4'hA};
    vt[4]  = '{1, 0, 0, 4'h5, 4'hA, 0, 0, 1, 4'h0};
    vt[5]  = '{1, 0, 1, 4'h5, 4'hA, 0, 1, 1, 4'hA};
    vt[6]  = '{1, 0, 0, 4'h5, 4'hA, 0, 0, 1, 4'h0};
    vt[7]  = '{1, 1, 1, 4'h5, 4'hA, 1, 0, 0, 4'h5};
    vt[8]  = '{1, 0, 0, 4'h5, 4'hA, 0, 0, 0, 4'h0};
    vt[9]  = '{1, 1, 1, 4'h3, 4'hC, 0, 1, 1, 4'hC};
    vt[10] = '{1, 0, 0, 4'h3, 4'hC, 0, 0, 1, 4'h0};
    vt[11] = '{1, 1, 1, 4'h9, 4'h6, 1, 0, 0, 4'h9};
    vt[12] = '{1, 0, 0, 4'h9, 4'h6, 0, 0, 0, 4'h0};

    resetn = 1'b0;
    req_x  = 1'b0;
    req_y  = 1'b0;
    data_x = '0;
    data_y = '0;

    foreach (vt[i]) begin
      drive(vt[i].rn, vt[i].rx, vt[i].ry, vt[i].dx, vt[i].dy);
      cmp($sformatf("vec%0d", i), pack_out(),
          {vt[i].gx, vt[i].gy, vt[i].s, vt[i].gx | vt[i].gy, vt[i].em});
    end

    // Contention held: X first after reset, alternating every HOLD_MAX.
    drive(0, 0, 0, 4'h1, 4'h2);
    cmp("tmo_rst", pack_out(), 8'h00);
    for (int i = 0; i < 3 * HOLD_MAX; i++) begin
      bit ex;
      drive(1, 1, 1, 4'h1, 4'h2);
      ex = TMO ? ((i / HOLD_MAX) % 2 == 0) : 1'b1;
      cmp($sformatf("tmo%0d", i), {6'd0, gnt_x, gnt_y}, {6'd0, ex, ~ex});
    end

    // Reset during a Y grant with X requesting: no handoff.
    drive(1, 0, 0, 4'h1, 4'h2);
    drive(1, 0, 1, 4'h1, 4'h2);
    cmp("midg_gy", pack_out(), {4'b0111, 4'h2});
    drive(0, 1, 1, 4'h1, 4'h2);
    cmp("midg_rst", pack_out(), 8'h00);
    for (int i = 0; i < HOLD_MAX + 2; i++) begin
      drive(1, 1, 1, 4'h1, 4'h2);
      cmp($sformatf("midg_hold%0d", i), pack_out(), pack_model());
    end

    // Randomized traffic with sticky requests and rare resets.
    for (int i = 0; i < 600; i++) begin
      bit rn, rx, ry;
      rn = ($urandom_range(0, 39) != 0);
      rx = ($urandom_range(0, 3) == 0) ? ~req_x : req_x;
      ry = ($urandom_range(0, 3) == 0) ? ~req_y : req_y;
      drive(rn, rx, ry, 4'($urandom), 4'($urandom));
      cmp("rand", pack_out(), pack_model());
      if (gnt_x && gnt_y) cmp("excl", 8'h03, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
